// File: rtl/dm_ls_mem.sv
// Word-organised data memory: byte/half/word loads and stores, a self-clearing
// init phase after reset, fixed access latency and alignment/range faults.
module dm_ls_mem #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned WORDS   = 3072,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [31:0] req_pc_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_fault_o,
    output logic        init_done_o
);

    localparam int unsigned IdxW  = ADDR_W - 2;
    localparam int unsigned MemAw = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned LatW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StInit, StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] init_cnt_q, init_cnt_d;
    logic [LatW-1:0] lat_cnt_q, lat_cnt_d;
    logic            init_done_q, init_done_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_fault_q, rsp_fault_d;

    logic            we_q, uns_q;
    logic [1:0]      size_q;
    logic [31:0]     addr_q, wdata_q, pc_q;

    logic [31:0]     mem_q [WORDS];

    logic            accept, commit, fault;
    logic [IdxW-1:0] idx;
    logic [31:0]     old_word, merged_word, lane_data, load_data, shifted;
    logic [3:0]      lane_mask;
    logic [15:0]     ld_half;
    logic            mem_we;
    logic [MemAw-1:0] mem_waddr;
    logic [31:0]     mem_wdata;

    // Control FSM: clear sweep, accept, latency countdown, one-cycle response.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        init_done_d = init_done_q;
        accept      = 1'b0;
        commit      = 1'b0;
        case (state_q)
            StInit: begin
                if (init_cnt_q == IdxW'(WORDS - 1)) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + IdxW'(1);
                end
            end
            StIdle: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = StWait;
                    // Loaded with LATENCY-1 so the commit lands LATENCY edges after acceptance.
                    lat_cnt_d = LatW'(LATENCY - 1);
                end
            end
            StWait: begin
                if (lat_cnt_q == '0) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - LatW'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StInit;
        endcase
    end

    // Fault decode, store lane merge and load extraction on the captured request.
    always_comb begin
        idx = addr_q[ADDR_W-1:2];
        case (size_q)
            2'b00:   fault = 1'b0;
            2'b01:   fault = addr_q[0];
            2'b10:   fault = |addr_q[1:0];
            default: fault = 1'b1;
        endcase
        if (32'(idx) >= WORDS) begin
            fault = 1'b1;
        end

        old_word  = mem_q[idx[MemAw-1:0]];
        lane_mask = 4'b1111;
        lane_data = wdata_q;
        case (size_q)
            2'b00: begin
                lane_mask = 4'b0001 << addr_q[1:0];
                lane_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata_q[15:0]}};
            end
            default: lane_mask = 4'b1111;
        endcase
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lane_mask[i]) begin
                merged_word[8*i +: 8] = lane_data[8*i +: 8];
            end
        end

        shifted = old_word >> {addr_q[1:0], 3'b000};
        ld_half = addr_q[1] ? old_word[31:16] : old_word[15:0];
        case (size_q)
            2'b00:   load_data = uns_q ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_data = old_word;
        endcase

        rsp_rdata_d = rsp_rdata_q;
        rsp_fault_d = rsp_fault_q;
        if (commit) begin
            rsp_rdata_d = (fault || we_q) ? 32'h0 : load_data;
            rsp_fault_d = fault;
        end

        if (state_q == StInit) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt_q[MemAw-1:0];
            mem_wdata = 32'h0;
        end else begin
            mem_we    = commit && we_q && !fault;
            mem_waddr = idx[MemAw-1:0];
            mem_wdata = merged_word;
        end
    end

    // State, counters, captured request and held response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StInit;
            init_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            init_done_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_fault_q <= 1'b0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            pc_q        <= 32'h0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            init_done_q <= init_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
            if (accept) begin
                we_q    <= req_we_i;
                uns_q   <= req_unsigned_i;
                size_q  <= req_size_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                pc_q    <= req_pc_i;
            end
        end
    end

    // RAM array; no reset, the init sweep clears it after every reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

`ifndef SYNTHESIS
    // Store trace for each successful store commit.
    always_ff @(posedge clk_i) begin
        if (commit && we_q && !fault) begin
            $display("%d@%h: *%h <= %h", $time, pc_q, addr_q, merged_word);
        end
    end
`endif

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_fault_o = rsp_fault_q;
    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_dm_ls_mem.sv
// Bench for dm_ls_mem: instance 0 runs LATENCY=1, instance 1 runs LATENCY=3.
module tb_dm_ls_mem;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        flt;
    } op_t;

    localparam int Lim = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we [2];
    logic [1:0]  req_size [2];
    logic        req_uns [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [31:0] req_pc [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_fault [2];
    logic        init_done [2];

    int checks = 0;
    int errors = 0;
    op_t sb0 [$];
    op_t sb1 [$];

    always #5 clk = ~clk;

    dm_ls_mem #(.ADDR_W(14), .WORDS(3072), .LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
        .req_size_i(req_size[0]), .req_unsigned_i(req_uns[0]), .req_addr_i(req_addr[0]),
        .req_wdata_i(req_wdata[0]), .req_pc_i(req_pc[0]), .rsp_valid_o(rsp_valid[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_fault_o(rsp_fault[0]), .init_done_o(init_done[0])
    );

    dm_ls_mem #(.ADDR_W(14), .WORDS(3072), .LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
        .req_size_i(req_size[1]), .req_unsigned_i(req_uns[1]), .req_addr_i(req_addr[1]),
        .req_wdata_i(req_wdata[1]), .req_pc_i(req_pc[1]), .rsp_valid_o(rsp_valid[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_fault_o(rsp_fault[1]), .init_done_o(init_done[1])
    );

    function automatic op_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rd, input logic flt);
        mk = '{we: we, size: size, uns: uns, addr: addr, wdata: wdata, rd: rd, flt: flt};
    endfunction

    task automatic drive(input int s, input op_t o);
        req_we[s]    = o.we;
        req_size[s]  = o.size;
        req_uns[s]   = o.uns;
        req_addr[s]  = o.addr;
        req_wdata[s] = o.wdata;
        req_pc[s]    = $urandom;
        req_valid[s] = 1'b1;
    endtask

    // Garbage on the request bus after acceptance must not affect the transaction.
    task automatic scramble(input int s);
        req_valid[s] = 1'b0;
        req_we[s]    = 1'($urandom);
        req_size[s]  = 2'($urandom);
        req_uns[s]   = 1'($urandom);
        req_addr[s]  = $urandom;
        req_wdata[s] = $urandom;
    endtask

    task automatic run_op(input int s, input op_t o, output logic [31:0] rd,
                          output logic flt, output bit to);
        int n;
        @(negedge clk);
        drive(s, o);
        n = 0;
        while (req_ready[s] !== 1'b1 && n < Lim) begin
            @(negedge clk);
            n++;
        end
        to = (n >= Lim);
        @(negedge clk);
        scramble(s);
        n = 0;
        while (rsp_valid[s] !== 1'b1 && n < Lim) begin
            @(negedge clk);
            n++;
        end
        to = to || (n >= Lim);
        rd  = rsp_rdata[s];
        flt = rsp_fault[s];
    endtask

    task automatic test_reset;
        int cnt;
        bit early;
        #3;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (req_ready[s] !== 1'b0 || rsp_valid[s] !== 1'b0 || rsp_rdata[s] !== 32'h0 ||
                rsp_fault[s] !== 1'b0 || init_done[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_vals[%0d]: got rdy=%b vld=%b rd=%h flt=%b done=%b, want all 0",
                         s, req_ready[s], rsp_valid[s], rsp_rdata[s], rsp_fault[s], init_done[s]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt   = 0;
        early = 1'b0;
        while (cnt < 4000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (req_ready[0] === 1'b1) break;
            if (init_done[0] !== 1'b0 || init_done[1] !== 1'b0) early = 1'b1;
        end
        checks++;
        if (cnt != 3072) begin
            errors++;
            $display("FAIL init_cycles: got %0d edges, want 3072", cnt);
        end
        checks++;
        if (early || init_done[0] !== 1'b1 || init_done[1] !== 1'b1 || req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL init_done: got early=%b done=%b/%b rdy1=%b, want 0 1/1 1",
                     early, init_done[0], init_done[1], req_ready[1]);
        end
    endtask

    task automatic test_lanes;
        op_t ops [8];
        op_t e;
        logic [31:0] rd;
        logic flt;
        bit to;
        ops[0] = mk(1'b0, 2'd2, 1'b0, 32'h2FFC, 32'h0, 32'h0, 1'b0);
        ops[1] = mk(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b0);
        ops[2] = mk(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'h00000056, 1'b0);
        ops[3] = mk(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h00000012, 1'b0);
        ops[4] = mk(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h00001234, 1'b0);
        ops[5] = mk(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'h00005678, 1'b0);
        ops[6] = mk(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'h00000078, 1'b0);
        ops[7] = mk(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 32'h12345678, 1'b0);
        for (int i = 0; i < 8; i++) begin
            sb0.push_back(ops[i]);
            run_op(0, ops[i], rd, flt, to);
            e = sb0.pop_front();
            checks++;
            if (to || rd !== e.rd || flt !== e.flt) begin
                errors++;
                $display("FAIL lanes[%0d]: got rdata=%h fault=%b timeout=%b, want rdata=%h fault=%b",
                         i, rd, flt, to, e.rd, e.flt);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h12345678) begin
            errors++;
            $display("FAIL rsp_hold: got vld=%b rdata=%h, want 0 12345678", rsp_valid[0],
                     rsp_rdata[0]);
        end
    endtask

    task automatic test_partial;
        op_t ops [9];
        op_t e;
        logic [31:0] rd;
        logic flt;
        bit to;
        ops[0] = mk(1'b1, 2'd2, 1'b0, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0);
        ops[1] = mk(1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFFFF80, 32'h0, 1'b0);
        ops[2] = mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hAABB80DD, 1'b0);
        ops[3] = mk(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0);
        ops[4] = mk(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 32'h00000080, 1'b0);
        ops[5] = mk(1'b1, 2'd1, 1'b0, 32'h22, 32'h12349999, 32'h0, 1'b0);
        ops[6] = mk(1'b0, 2'd2, 1'b1, 32'h20, 32'h0, 32'h999980DD, 1'b0);
        ops[7] = mk(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'hFFFF9999, 1'b0);
        ops[8] = mk(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h00009999, 1'b0);
        for (int i = 0; i < 9; i++) begin
            sb0.push_back(ops[i]);
            run_op(0, ops[i], rd, flt, to);
            e = sb0.pop_front();
            checks++;
            if (to || rd !== e.rd || flt !== e.flt) begin
                errors++;
                $display("FAIL partial[%0d]: got rdata=%h fault=%b timeout=%b, want rdata=%h fault=%b",
                         i, rd, flt, to, e.rd, e.flt);
            end
        end
    endtask

    task automatic test_faults;
        op_t ops [10];
        op_t e;
        logic [31:0] rd;
        logic flt;
        bit to;
        ops[0] = mk(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
        ops[1] = mk(1'b1, 2'd2, 1'b0, 32'h22, 32'h11111111, 32'h0, 1'b1);
        ops[2] = mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h999980DD, 1'b0);
        ops[3] = mk(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 32'h0, 1'b1);
        ops[4] = mk(1'b1, 2'd0, 1'b0, 32'h3003, 32'h000000AB, 32'h0, 1'b1);
        ops[5] = mk(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1);
        ops[6] = mk(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
        ops[7] = mk(1'b1, 2'd1, 1'b0, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b1);
        ops[8] = mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0);
        ops[9] = mk(1'b0, 2'd2, 1'b0, 32'h2FFC, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            sb0.push_back(ops[i]);
            run_op(0, ops[i], rd, flt, to);
            e = sb0.pop_front();
            checks++;
            if (to || rd !== e.rd || flt !== e.flt) begin
                errors++;
                $display("FAIL faults[%0d]: got rdata=%h fault=%b timeout=%b, want rdata=%h fault=%b",
                         i, rd, flt, to, e.rd, e.flt);
            end
        end
    endtask

    // Cycle k is the interval between edge k-1 and edge k, with acceptance at edge 0.
    task automatic test_back_to_back;
        op_t o0, o1, e;
        bit exp_rv, exp_rdy;
        o0 = mk(1'b1, 2'd2, 1'b0, 32'h50, 32'hCAFEF00D, 32'h0, 1'b0);
        o1 = mk(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        checks++;
        if (req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL l3_idle: got ready=%b, want 1", req_ready[1]);
        end
        drive(1, o0);
        sb1.push_back(o0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1 || k == 6) scramble(1);
            exp_rv  = (k == 4) || (k == 9);
            exp_rdy = (k == 5) || (k == 10);
            checks++;
            if (rsp_valid[1] !== exp_rv || req_ready[1] !== exp_rdy) begin
                errors++;
                $display("FAIL latency_cycle[%0d]: got vld=%b rdy=%b, want vld=%b rdy=%b",
                         k, rsp_valid[1], req_ready[1], exp_rv, exp_rdy);
            end
            if (rsp_valid[1] === 1'b1 && sb1.size() > 0) begin
                e = sb1.pop_front();
                checks++;
                if (rsp_rdata[1] !== e.rd || rsp_fault[1] !== e.flt) begin
                    errors++;
                    $display("FAIL latency_rsp[%0d]: got rdata=%h fault=%b, want rdata=%h fault=%b",
                             k, rsp_rdata[1], rsp_fault[1], e.rd, e.flt);
                end
            end
            if (k == 5) begin
                drive(1, o1);
                sb1.push_back(o1);
            end
        end
        checks++;
        if (sb1.size() != 0) begin
            errors++;
            $display("FAIL latency_drain: got %0d pending, want 0", sb1.size());
            sb1.delete();
        end
    endtask

    task automatic test_reset_midop;
        op_t o, e;
        logic [31:0] rd;
        logic flt;
        bit to, seen;
        int cnt;
        o = mk(1'b1, 2'd2, 1'b0, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b0);
        @(negedge clk);
        drive(1, o);
        @(negedge clk);
        scramble(1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0 || init_done[1] !== 1'b0 ||
            init_done[0] !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: got rdy=%b vld=%b done=%b/%b, want 0 0 0/0",
                     req_ready[1], rsp_valid[1], init_done[0], init_done[1]);
        end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0) seen = 1'b1;
        end
        rst_n = 1'b1;
        cnt = 0;
        while (cnt < 4000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (rsp_valid[0] !== 1'b0 || rsp_valid[1] !== 1'b0) seen = 1'b1;
            if (req_ready[1] === 1'b1) break;
        end
        checks++;
        if (seen || cnt != 3072) begin
            errors++;
            $display("FAIL midop_reinit: got stray_rsp=%b edges=%0d, want 0 3072", seen, cnt);
        end
        o = mk(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
        sb1.push_back(o);
        run_op(1, o, rd, flt, to);
        e = sb1.pop_front();
        checks++;
        if (to || rd !== e.rd || flt !== e.flt) begin
            errors++;
            $display("FAIL midop_lw40: got rdata=%h fault=%b timeout=%b, want rdata=%h fault=%b",
                     rd, flt, to, e.rd, e.flt);
        end
        o = mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        sb0.push_back(o);
        run_op(0, o, rd, flt, to);
        e = sb0.pop_front();
        checks++;
        if (to || rd !== e.rd || flt !== e.flt) begin
            errors++;
            $display("FAIL reclear_lw10: got rdata=%h fault=%b timeout=%b, want rdata=%h fault=%b",
                     rd, flt, to, e.rd, e.flt);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0;
            req_we[s]    = 1'b0;
            req_size[s]  = 2'b00;
            req_uns[s]   = 1'b0;
            req_addr[s]  = 32'h0;
            req_wdata[s] = 32'h0;
            req_pc[s]    = 32'h0;
        end
        test_reset();
        test_lanes();
        test_partial();
        test_faults();
        test_back_to_back();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
